// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : ALU opcode constants, arbiter state encoding and default width.
//  Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef logic [2:0] aluop_t;

    localparam aluop_t ALUOP_ADD     = 3'd0;
    localparam aluop_t ALUOP_SUB     = 3'd1;
    localparam aluop_t ALUOP_AND     = 3'd2;
    localparam aluop_t ALUOP_OR      = 3'd3;
    localparam aluop_t ALUOP_SLL     = 3'd4;
    localparam aluop_t ALUOP_SRL     = 3'd5;
    localparam aluop_t ALUOP_SLT     = 3'd6;
    localparam aluop_t ALUOP_ILLEGAL = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_if
//  Brief    : Requester-side request/response bundle for alu_arbiter.
//  Revision : 1.0
// ============================================================================
interface alu_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = alu_pkg::ALU_WIDTH
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_zero;
    logic                  rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick: first request at or above ptr.
//  Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_any
);

    always_comb begin
        int k;
        k         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            k = int'(ptr) + off;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!grant_any && req[k]) begin
                grant_any = 1'b1;
                grant_idx = IDXW'(k);
                grant[k]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Brief    : Round-robin sharing of one registered ALU among NREQ requesters.
//             Optional per-requester response counters: ALU_ARB_PERF_EN.
//  Revision : 1.0
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_arbiter_if.slave       bus,
    output logic [WIDTH-1:0]   alu_in1,
    output logic [WIDTH-1:0]   alu_in2,
    output logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_zero,
`ifdef ALU_ARB_PERF_EN
    output logic [32*NREQ-1:0] grant_cnt,
`endif
    output logic               busy
);

    localparam int IDXW = $clog2(NREQ);

    logic [1:0]       state_q,    state_d;
    logic [IDXW-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [IDXW-1:0]  grant_q,    grant_d;
    logic [WIDTH-1:0] alu_in1_q,  alu_in1_d;
    logic [WIDTH-1:0] alu_in2_q,  alu_in2_d;
    logic [2:0]       alu_op_q,   alu_op_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q,  rsp_err_d;

    logic [NREQ-1:0]  gnt_vec;
    logic [IDXW-1:0]  gnt_idx;
    logic             gnt_any;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] cnt_q [NREQ];
    logic [31:0] cnt_d [NREQ];
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (gnt_vec),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    assign sel_op = bus.req_op[3*int'(gnt_idx) +: 3];
    assign sel_a  = bus.req_a[WIDTH*int'(gnt_idx) +: WIDTH];
    assign sel_b  = bus.req_b[WIDTH*int'(gnt_idx) +: WIDTH];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        alu_in1_d  = alu_in1_q;
        alu_in2_d  = alu_in2_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
`ifdef ALU_ARB_PERF_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    grant_d = gnt_idx;
                    // Illegal ops bypass the ALU so its inputs keep the last legal launch.
                    if (sel_op == ALUOP_ILLEGAL) begin
                        rsp_data_d = '0;
                        rsp_zero_d = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        alu_in1_d  = sel_a;
                        alu_in2_d  = sel_b;
                        alu_op_d   = sel_op;
                        rsp_err_d  = 1'b0;
                        state_d    = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                rsp_data_d = alu_out;
                rsp_zero_d = alu_zero;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready[grant_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;
`ifdef ALU_ARB_PERF_EN
                    cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            alu_in1_q  <= '0;
            alu_in2_q  <= '0;
            alu_op_q   <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
`ifdef ALU_ARB_PERF_EN
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            alu_in1_q  <= alu_in1_d;
            alu_in2_q  <= alu_in2_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
`ifdef ALU_ARB_PERF_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_hs
            assign bus.req_ready[i] = (state_q == ST_IDLE) && gnt_vec[i];
            assign bus.rsp_valid[i] = (state_q == ST_RESP) && (int'(grant_q) == i);
        end
`ifdef ALU_ARB_PERF_EN
        for (genvar i = 0; i < NREQ; i++) begin : g_cnt
            assign grant_cnt[32*i +: 32] = cnt_q[i];
        end
`endif
    endgenerate

    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_zero = rsp_zero_q;
    assign bus.rsp_err  = rsp_err_q;
    assign alu_in1      = alu_in1_q;
    assign alu_in2      = alu_in2_q;
    assign alu_op       = alu_op_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire
